// File: rtl/ifstage_if.sv
// ifstage_if: fetch-stage bundle -- imem request/grant/response, decode handoff and redirect.
interface ifstage_if;
  logic imem_req, imem_gnt, imem_rvalid, instr_valid, instr_ready, redirect;
  logic [31:0] imem_addr, imem_rdata, instruction, pc, redirect_pc;
  modport master(
    output imem_req, imem_addr, instr_valid, instruction, pc,
    input imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
  );
  modport slave(
    input imem_req, imem_addr, instr_valid, instruction, pc,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/ifstage.sv
// ifstage: rv32i fetch stage with credit-limited prefetch FIFO and redirect flush.
module ifstage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 2
) (
  input logic clk_i,
  input logic rst_i,
  ifstage_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);
  logic [31:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0] out_q, out_d, disc_q, disc_d, cnt_q, cnt_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [63:0] mem_q [FIFO_DEPTH];
  logic [63:0] mem_d [FIFO_DEPTH];
  logic [63:0] head;
  logic fire, rv, push, pop, valid, unused;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == LAST ? '0 : p + 1'b1;
  endfunction
  assign unused = ^bus.redirect_pc[1:0];
  assign valid = !rst_i && cnt_q != '0;
  assign head = mem_q[rd_q];
  // credit: buffered plus in-flight never exceeds the FIFO, so pushes always fit
  assign bus.imem_req = !rst_i && ({1'b0, cnt_q} + {1'b0, out_q}) < DEPTH_W;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.instr_valid = valid;
  assign bus.instruction = valid ? head[31:0] : '0;
  assign bus.pc = valid ? head[63:32] : '0;
  assign fire = bus.imem_req && bus.imem_gnt;
  assign rv = bus.imem_rvalid && out_q != '0;
  assign push = rv && disc_q == '0;
  assign pop = valid && bus.instr_ready;
  always_comb begin
    out_d = out_q + CW'(fire) - CW'(rv);
    mem_d = mem_q;
    if (push) mem_d[wr_q] = {resp_pc_q, bus.imem_rdata};
    fetch_pc_d = bus.redirect ? {bus.redirect_pc[31:2], 2'b00} : fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
    resp_pc_d = bus.redirect ? {bus.redirect_pc[31:2], 2'b00} : push ? resp_pc_q + 32'd4 : resp_pc_q;
    // every response still owed at the end of a redirect cycle belongs to the old stream
    disc_d = bus.redirect ? out_d : (rv && disc_q != '0) ? disc_q - 1'b1 : disc_q;
    cnt_d = bus.redirect ? '0 : cnt_q + CW'(push) - CW'(pop);
    wr_d = bus.redirect ? '0 : push ? inc(wr_q) : wr_q;
    rd_d = bus.redirect ? '0 : pop ? inc(rd_q) : rd_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q <= RESET_PC;
      out_q <= '0;
      disc_q <= '0;
      cnt_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q <= resp_pc_d;
      out_q <= out_d;
      disc_q <= disc_d;
      cnt_q <= cnt_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
    end
    mem_q <= mem_d;
  end
endmodule

// File: tb/tb_ifstage.sv
// tb_ifstage: randomized fetch-stage bench with memory model and in-order stream scoreboard.
module tb_ifstage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int DEPTH = 2;
  typedef struct {logic [31:0] a; int due;} req_t;
  typedef struct {int e; logic [31:0] pc;} ev_t;
  logic clk = 0, rst = 1;
  int cyc = 0, n_cmp = 0, n_bad = 0, ntx = 0;
  int gnt_pct = 100, rdy_pct = 100, dmin = 1, dmax = 1, redir_pct = 0;
  logic inj_stale = 0, force_v = 0;
  logic [31:0] force_tgt = '0, exp_pc = RESET_PC, exp_fa = RESET_PC;
  req_t pend[$];
  ev_t ev_q[$];
  ifstage_if bus();
  ifstage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut(.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // memory and decode driver: inputs change 2 time units after each rising edge
  initial begin : drv
    logic [31:0] t;
    forever begin
      @(posedge clk);
      #2;
      bus.imem_gnt = $urandom_range(99) < gnt_pct;
      bus.instr_ready = $urandom_range(99) < rdy_pct;
      bus.imem_rvalid = 0;
      bus.imem_rdata = $urandom;
      bus.redirect = 0;
      bus.redirect_pc = $urandom;
      if (rst) pend.delete();
      else if (inj_stale) begin
        bus.imem_rvalid = 1;
        inj_stale = 0;
      end else if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
        bus.imem_rvalid = 1;
        bus.imem_rdata = word(pend[0].a);
        pend.pop_front();
      end
      if (!rst && (force_v || $urandom_range(99) < redir_pct)) begin
        t = force_v ? force_tgt : ($urandom_range(3) == 0 ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom);
        force_v = 0;
        bus.redirect = 1;
        bus.redirect_pc = t;
        ev_q.push_back('{cyc + 1, {t[31:2], 2'b00}});
      end
    end
  end
  // monitor: everything sampled here takes effect at the next rising edge
  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk("rst_req", 32'(bus.imem_req), 0);
      chk("rst_valid", 32'(bus.instr_valid), 0);
      chk("rst_instr", bus.instruction, 0);
      chk("rst_pc", bus.pc, 0);
      exp_pc = RESET_PC;
      exp_fa = RESET_PC;
    end else begin
      if (bus.imem_req) chk("req_addr", bus.imem_addr, exp_fa);
      if (bus.imem_req && bus.imem_gnt) begin
        pend.push_back('{bus.imem_addr, cyc + 1 + $urandom_range(dmax, dmin)});
        exp_fa += 4;
      end
      if (bus.instr_valid && bus.instr_ready) begin
        chk("out_pc", bus.pc, exp_pc);
        chk("out_instr", bus.instruction, word(exp_pc));
        exp_pc += 4;
        ntx++;
      end else if (!bus.instr_valid) chk("idle_zero", bus.pc | bus.instruction, 0);
    end
    while (ev_q.size() > 0 && ev_q[0].e <= cyc + 1) begin
      if (ev_q[0].e == cyc + 1 && !rst) begin
        exp_pc = ev_q[0].pc;
        exp_fa = ev_q[0].pc;
      end
      ev_q.pop_front();
    end
  end
  initial begin
    bus.imem_gnt = 0;
    bus.imem_rvalid = 0;
    bus.imem_rdata = '0;
    bus.instr_ready = 0;
    bus.redirect = 0;
    bus.redirect_pc = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    inj_stale = 1;
    @(negedge clk);
    chk("first_req", 32'(bus.imem_req), 1);
    chk("first_addr", bus.imem_addr, RESET_PC);
    @(negedge clk);
    chk("lat_n1_valid", 32'(bus.instr_valid), 0);
    @(negedge clk);
    chk("lat_n2_valid", 32'(bus.instr_valid), 1);
    chk("lat_n2_pc", bus.pc, RESET_PC);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 rdy_pct = 0;
    repeat (10) @(negedge clk);
    chk("stall_req", 32'(bus.imem_req), 0);
    chk("stall_valid", 32'(bus.instr_valid), 1);
    chk("stall_head_pc", bus.pc, exp_pc);
    chk("stall_head_instr", bus.instruction, word(exp_pc));
    @(posedge clk);
    #1 rdy_pct = 100;
    dmin = 2;
    dmax = 2;
    repeat (8) @(posedge clk);
    #1 force_tgt = 32'h100;
    force_v = 1;
    @(negedge clk);
    @(negedge clk);
    chk("redir_addr", bus.imem_addr, 32'h100);
    repeat (8) @(posedge clk);
    #1 force_tgt = 32'h103;
    force_v = 1;
    @(negedge clk);
    @(negedge clk);
    chk("redir_unaligned", bus.imem_addr, 32'h100);
    repeat (8) @(posedge clk);
    #1 dmin = 1;
    dmax = 1;
    force_tgt = 32'hFFFF_FFFC;
    force_v = 1;
    @(negedge clk);
    @(negedge clk);
    chk("redir_wrap", bus.imem_addr, 32'hFFFF_FFFC);
    repeat (10) @(posedge clk);
    #1 dmin = 2;
    dmax = 2;
    rdy_pct = 0;
    repeat (4) @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    chk("pulse_rst_valid", 32'(bus.instr_valid), 0);
    @(posedge clk);
    #1 rst = 0;
    inj_stale = 1;
    rdy_pct = 100;
    @(negedge clk);
    chk("restart_addr", bus.imem_addr, RESET_PC);
    chk("restart_valid", 32'(bus.instr_valid), 0);
    for (int b = 0; b < 40; b++) begin
      @(posedge clk);
      #1 gnt_pct = $urandom_range(100, 40);
      rdy_pct = $urandom_range(100, 20);
      dmin = 1;
      dmax = $urandom_range(4, 1);
      redir_pct = $urandom_range(8, 0);
      if (b % 10 == 9) begin
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        inj_stale = 1;
      end
      repeat (60) @(posedge clk);
    end
    #1 gnt_pct = 100;
    rdy_pct = 100;
    redir_pct = 0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("liveness", 32'(ntx > 200), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
